// File: rtl/icache.sv
// icache: direct-mapped instruction cache, one 32-bit word per line, refilled
// byte by byte over a shared 8-bit read bus.
// Optional feature macro ICACHE_EN: when defined, tag/data/valid storage and the
// one-cycle hit path exist; when undefined every request refills from the bus.
module icache #(
    parameter int unsigned INDEX_BITS = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req_i,
    input  logic [16:0] fetch_addr_i,
    input  logic        flush_i,
    input  logic        mem_grant_i,
    input  logic [7:0]  mem_data_i,
    output logic        mem_req_o,
    output logic [16:0] mem_addr_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);
    localparam int unsigned ADDR_W  = 17;
    localparam int unsigned WADDR_W = ADDR_W - 2;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WADDR_W-1:0] word_addr_q;
    logic [2:0]         issue_cnt_q;
    logic [1:0]         recv_cnt_q;
    logic               pend_q;
    logic [23:0]        part_q;
    logic               valid_q;

    logic               accept;
    logic               hit;
    logic               issue;
    logic               capture;
    logic               last;
    logic [31:0]        hit_data;

    // Byte offset within the word is irrelevant: lines hold whole words.
    logic unused_offset;
    assign unused_offset = ^fetch_addr_i[1:0];

`ifdef ICACHE_EN
    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = ADDR_W - 2 - INDEX_BITS;

    logic [LINES-1:0]      line_valid_q;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_W-1:0]      fill_tag;

    assign idx      = fetch_addr_i[INDEX_BITS+1:2];
    assign tag      = fetch_addr_i[ADDR_W-1:INDEX_BITS+2];
    assign fill_idx = word_addr_q[INDEX_BITS-1:0];
    assign fill_tag = word_addr_q[WADDR_W-1:INDEX_BITS];
    assign hit      = line_valid_q[idx] && (tag_mem[idx] == tag);
    assign hit_data = data_mem[idx];

    // Valid bits: cleared by reset, set when a refill completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid_q <= '0;
        end else if (last) begin
            line_valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays, written with the assembled word on refill completion.
    always_ff @(posedge clk) begin
        if (last) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= {mem_data_i, part_q};
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle strobes; flush dominates every action.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        issue   = 1'b0;
        capture = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                // Requests during the result pulse belong to the finished fetch.
                accept = fetch_req_i && !flush_i && !valid_q;
                if (accept && !hit) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                issue   = !flush_i && mem_grant_i && (issue_cnt_q < 3'd4);
                capture = !flush_i && pend_q;
                last    = capture && (recv_cnt_q == 2'd3);
                if (flush_i || last) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Bus outputs follow the grant within the same cycle.
    assign mem_req_o    = issue;
    assign mem_addr_o   = issue ? {word_addr_q, issue_cnt_q[1:0]} : '0;
    assign inst_valid_o = valid_q && !flush_i;

    // Refill counters, byte assembly and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_addr_q <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            pend_q      <= 1'b0;
            part_q      <= '0;
            valid_q     <= 1'b0;
            inst_o      <= '0;
        end else begin
            valid_q <= 1'b0;
            pend_q  <= issue;
            if (flush_i) begin
                issue_cnt_q <= '0;
                recv_cnt_q  <= '0;
            end
            if (accept) begin
                word_addr_q <= fetch_addr_i[ADDR_W-1:2];
                issue_cnt_q <= '0;
                recv_cnt_q  <= '0;
                if (hit) begin
                    valid_q <= 1'b1;
                    inst_o  <= hit_data;
                end
            end
            if (issue) begin
                issue_cnt_q <= issue_cnt_q + 3'd1;
            end
            if (capture) begin
                recv_cnt_q <= recv_cnt_q + 2'd1;
                case (recv_cnt_q)
                    2'd0:    part_q[7:0]   <= mem_data_i;
                    2'd1:    part_q[15:8]  <= mem_data_i;
                    2'd2:    part_q[23:16] <= mem_data_i;
                    default: ;
                endcase
            end
            if (last) begin
                valid_q <= 1'b1;
                inst_o  <= {mem_data_i, part_q};
            end
        end
    end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_BITS, default 7, SHALL set line count to 2^INDEX_BITS, one 32-bit word per line.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 fetch_req_i  input  1  fetch request, held until inst_valid_o or flush_i.
REQ-005 fetch_addr_i  input  17  byte address of instruction; bits [1:0] SHALL be ignored.
REQ-006 flush_i  input  1  pc changed; abort current fetch.
REQ-007 mem_grant_i  input  1  bus arbiter grants byte bus this cycle (data-side has priority).
REQ-008 mem_data_i  input  8  read byte, valid one cycle after its address is issued.
REQ-009 mem_req_o  output  1  byte read issued this cycle.
REQ-010 mem_addr_o  output  17  byte address of issued read.
REQ-011 inst_o  output  32  instruction word, little-endian.
REQ-012 inst_valid_o  output  1  one-cycle pulse, inst_o valid.

Function
REQ-013 Address split SHALL be: offset [1:0], index [INDEX_BITS+1:2], tag [16:INDEX_BITS+2].
REQ-014 FSM states SHALL be IDLE and REFILL.
REQ-015 IDLE, fetch_req_i=1, flush_i=0, valid[index] and tag match: inst_valid_o=1 and inst_o=line data in the next cycle (hit latency 1); stay IDLE.
REQ-016 IDLE, fetch_req_i=1, flush_i=0, miss: capture word address, go REFILL, issue_cnt=0, recv_cnt=0.
REQ-017 REFILL: when issue_cnt<4 and mem_grant_i=1, mem_req_o=1, mem_addr_o={word_addr,issue_cnt[1:0]}, issue_cnt increments; mem_grant_i=0 SHALL pause issue, counts unchanged.
REQ-018 Each byte SHALL be captured from mem_data_i the cycle after its issue into byte lane recv_cnt; recv_cnt increments.
REQ-019 On capture of byte 3: line written (data, tag, valid=1), inst_valid_o=1 with assembled word next cycle, return IDLE.
REQ-020 Miss latency with continuous grant SHALL be 6 cycles from request to inst_valid_o.
REQ-021 flush_i=1 in any state SHALL: return IDLE next cycle, discard partial word and in-flight byte, suppress line write and inst_valid_o; a request sampled with flush_i=1 SHALL be ignored.
REQ-022 inst_valid_o SHALL never assert in the same cycle as flush_i=1.
REQ-023 mem_req_o SHALL be 0 in IDLE; no more than 4 reads per refill.
REQ-024 A new request SHALL be accepted no earlier than the cycle after inst_valid_o.
REQ-025 Lines SHALL be replaced direct-mapped, no write path from data side (code is read-only).

Reset
REQ-026 rst=1 SHALL clear all valid bits, FSM to IDLE, counters 0, mem_req_o=0, mem_addr_o=0, inst_o=0, inst_valid_o=0.
REQ-027 rst mid-refill SHALL abort with no line write and no inst_valid_o.

Configuration
REQ-028 Macro ICACHE_EN defined: storage and hit path present per REQ-015/019.
REQ-029 ICACHE_EN undefined: no tag/data/valid storage; every request SHALL take the REFILL path (always miss), all other timing unchanged.

Verification
REQ-030 After reset, fetch 0x00004, grant=1, bytes 13,00,10,00 -> mem_addr_o 0x4..0x7, inst_valid_o at cycle 6, inst_o=0x00100013.
REQ-031 Repeat fetch 0x00004 (ICACHE_EN) -> mem_req_o stays 0, inst_valid_o next cycle, inst_o=0x00100013; without ICACHE_EN -> full refill again.
REQ-032 Fetch 0x00204 after 0x00004 (same index, INDEX_BITS=7) -> miss, refill, line replaced; refetch 0x00004 misses.
REQ-033 Refill with mem_grant_i low for 3 cycles after byte 1 -> no issue during gap, inst_valid_o at cycle 9, correct word.
REQ-034 flush_i=1 after byte 2 issued -> IDLE next cycle, no inst_valid_o, no line write; subsequent fetch same address misses.
REQ-035 rst=1 during refill byte 1 -> outputs zero next cycle, later fetch to any address misses.
